keypad_lock_ctrl: RTL and testbench

Parametrised keypad combination-lock controller and successor to the fixed 3-digit lock. It decodes a 16-bit one-hot keypad bus and shifts digits into a BCD entry register of DIGITS nibbles that drives the 7-seg display path. It compares entries against a stored code, with code change allowed only while unlocked. It applies a retry limit with a timed, self-expiring lockout countdown, and drives a buzzer with distinct key, success and failure patterns.

---
 rtl/keypad_lock_pkg.sv | 59 +++++
 rtl/keypad_lock_ctrl_buzz_gen.sv | 89 ++++++++
 rtl/keypad_lock_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_keypad_lock_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_lock_pkg.sv
// keypad_lock_pkg
//   Shared definitions for the keypad combination lock: keypad bit
//   indices, display glyph nibbles, FSM and tone enums, and small
//   helpers for one-hot detection, key-to-digit decode and 2-digit
//   BCD decrement.
package keypad_lock_pkg;

   // Keypad bus bit indices
   localparam logic [3:0] K_0         = 4'd3;
   localparam logic [3:0] K_1         = 4'd7;
   localparam logic [3:0] K_2         = 4'd6;
   localparam logic [3:0] K_3         = 4'd5;
   localparam logic [3:0] K_4         = 4'd11;
   localparam logic [3:0] K_5         = 4'd10;
   localparam logic [3:0] K_6         = 4'd9;
   localparam logic [3:0] K_7         = 4'd15;
   localparam logic [3:0] K_8         = 4'd14;
   localparam logic [3:0] K_9         = 4'd13;
   localparam logic [3:0] K_ENTER     = 4'd0;
   localparam logic [3:0] K_SET       = 4'd4;
   localparam logic [3:0] K_CLR_ALL   = 4'd8;
   localparam logic [3:0] K_CLR_ENTRY = 4'd12;

   // Display glyphs understood by the 7-seg path
   localparam logic [3:0] GLYPH_BLANK = 4'hF;
   localparam logic [3:0] GLYPH_DASH  = 4'hD;
   localparam logic [3:0] GLYPH_OPEN  = 4'hB;

   typedef enum logic [1:0] {ST_ENTRY, ST_OPEN, ST_SET, ST_LOCKOUT} lock_state_e;
   typedef enum logic [1:0] {TONE_KEY, TONE_OK, TONE_FAIL} tone_e;

   function automatic logic is_onehot(input logic [15:0] v);
      return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
   endfunction

   // {valid, digit}; valid=0 for control or reserved keys
   function automatic logic [4:0] key_digit(input logic [3:0] idx);
      case (idx)
         K_0:     return {1'b1, 4'd0};
         K_1:     return {1'b1, 4'd1};
         K_2:     return {1'b1, 4'd2};
         K_3:     return {1'b1, 4'd3};
         K_4:     return {1'b1, 4'd4};
         K_5:     return {1'b1, 4'd5};
         K_6:     return {1'b1, 4'd6};
         K_7:     return {1'b1, 4'd7};
         K_8:     return {1'b1, 4'd8};
         K_9:     return {1'b1, 4'd9};
         default: return 5'd0;
      endcase
   endfunction

   // Two-digit BCD decrement with borrow (10 -> 09)
   function automatic logic [7:0] bcd_dec2(input logic [7:0] v);
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      else                return {v[7:4], v[3:0] - 4'd1};
   endfunction

endpackage

// File: rtl/keypad_lock_ctrl_buzz_gen.sv
// buzz_gen
//   Square-wave buzzer pattern engine. A start pulse (re)launches the
//   selected tone: output goes high the next cycle, toggles every HALF
//   cycles and stops after LEN cycles. The FAIL tone is muted in the
//   middle third of its duration to sound as two bursts.
// Ports:
//   clk    system clock
//   RSTn   asynchronous reset, active high
//   start  one-cycle launch request (preempts a running tone)
//   tone   tone selected at start
//   buzzer buzzer drive
module buzz_gen
   import keypad_lock_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic  clk,
   input  logic  RSTn,
   input  logic  start,
   input  tone_e tone,
   output logic  buzzer
);

   // Small test clocks can make HALF round to 0; keep at least one cycle
   function automatic int at_least_1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   localparam logic [31:0] KEY_HALF  = 32'(at_least_1(CLK_HZ / 1000));
   localparam logic [31:0] KEY_LEN   = 32'(at_least_1(CLK_HZ / 5));
   localparam logic [31:0] OK_HALF   = 32'(at_least_1(CLK_HZ / 2000));
   localparam logic [31:0] OK_LEN    = 32'(at_least_1(CLK_HZ * 3 / 5));
   localparam logic [31:0] FAIL_HALF = 32'(at_least_1(CLK_HZ / 500));
   localparam logic [31:0] FAIL_LEN  = 32'(at_least_1(CLK_HZ * 3 / 10));
   localparam logic [31:0] FAIL_LO   = FAIL_LEN / 32'd3;
   localparam logic [31:0] FAIL_HI   = (FAIL_LEN * 32'd2) / 32'd3;

   tone_e       tone_q;
   logic        active;
   logic        wave;
   logic [31:0] cnt;
   logic [31:0] half_cnt;
   logic [31:0] half;
   logic [31:0] len;
   logic        mute;

   always_comb begin
      half = KEY_HALF;
      len  = KEY_LEN;
      case (tone_q)
         TONE_OK:   begin half = OK_HALF;   len = OK_LEN;   end
         TONE_FAIL: begin half = FAIL_HALF; len = FAIL_LEN; end
         default:   begin half = KEY_HALF;  len = KEY_LEN;  end
      endcase
   end

   always_ff @(posedge clk or posedge RSTn) begin
      if (RSTn) begin
         tone_q   <= TONE_KEY;
         active   <= 1'b0;
         wave     <= 1'b0;
         cnt      <= '0;
         half_cnt <= '0;
      end else if (start) begin
         tone_q   <= tone;
         active   <= 1'b1;
         wave     <= 1'b1;
         cnt      <= '0;
         half_cnt <= '0;
      end else if (active) begin
         cnt <= cnt + 32'd1;
         if (half_cnt == half - 32'd1) begin
            half_cnt <= '0;
            wave     <= ~wave;
         end else begin
            half_cnt <= half_cnt + 32'd1;
         end
         // Final cycle of the pattern: go silent and idle
         if (cnt == len - 32'd1) begin
            active <= 1'b0;
            wave   <= 1'b0;
         end
      end
   end

   assign mute   = (tone_q == TONE_FAIL) && (cnt > FAIL_LO) && (cnt < FAIL_HI);
   assign buzzer = active & wave & ~mute;

endmodule

// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl
//   Keypad combination lock. Decodes a one-hot keypad bus into press
//   events, shifts digits into a BCD entry/display register, compares
//   against the stored code, counts failures into a timed lockout and
//   launches buzzer tones.
// Ports:
//   clk        system clock
//   RSTn       asynchronous reset, active high
//   key_onehot keypad bus, one bit per key
//   disp_bcd   display nibbles, [3:0] rightmost
//   digit_cnt  digits currently entered
//   tries      consecutive failures
//   locked     1 unless in OPEN or SET
//   lockout    1 in LOCKOUT
//   buzzer     buzzer drive
//   state_dbg  current FSM state (lock_state_e encoding)
// Handshake: key_onehot is sampled every cycle; a press is a registered
// exactly-one-hot value that differs from the previous sample, so a held
// key acts once and its effect appears two clock edges after the change.
module keypad_lock_ctrl
   import keypad_lock_pkg::*;
#(
   parameter int DIGITS    = 3,
   parameter int MAX_TRIES = 3,
   parameter int LOCK_SECS = 20,
   parameter int CLK_HZ    = 50_000_000,
   parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 12'h246
) (
   input  logic                clk,
   input  logic                RSTn,
   input  logic [15:0]         key_onehot,
   output logic [4*DIGITS-1:0] disp_bcd,
   output logic [3:0]          digit_cnt,
   output logic [3:0]          tries,
   output logic                locked,
   output logic                lockout,
   output logic                buzzer,
   output logic [1:0]          state_dbg
);

   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0]  ALL_BLANK = {DIGITS{GLYPH_BLANK}};
   localparam logic [W-1:0]  ALL_DASH  = {DIGITS{GLYPH_DASH}};
   localparam logic [W-1:0]  ALL_OPEN  = {DIGITS{GLYPH_OPEN}};
   localparam logic [7:0]    LOCK_BCD  = 8'(((LOCK_SECS / 10) * 16) + (LOCK_SECS % 10));
   localparam logic [31:0]   TICK_LAST = 32'(CLK_HZ - 1);
   localparam logic [3:0]    FULL_CNT  = 4'(DIGITS);
   localparam logic [3:0]    TRY_LIMIT = 4'(MAX_TRIES);

   lock_state_e state, state_n;
   logic [15:0] key_q, key_prev;
   logic [W-1:0] disp, disp_n, code, code_n;
   logic [3:0]  cnt, cnt_n, tries_q, tries_n;
   logic [31:0] tick_cnt, tick_n;
   logic        press;
   logic [3:0]  key_idx;
   logic [4:0]  kd;
   logic        is_digit;
   logic        full;
   logic [W-1:0] shifted;
   logic        tone_start;
   tone_e       tone_sel;

   assign press    = is_onehot(key_q) && (key_q != key_prev);
   assign kd       = key_digit(key_idx);
   assign is_digit = kd[4];
   assign full     = (cnt == FULL_CNT);
   assign shifted  = {disp[W-5:0], kd[3:0]};

   always_comb begin
      key_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (key_q[i]) key_idx = 4'(i);
      end
   end

   always_ff @(posedge clk or posedge RSTn) begin
      if (RSTn) begin
         key_q    <= '0;
         key_prev <= '0;
         state    <= ST_ENTRY;
         disp     <= ALL_BLANK;
         code     <= DEFAULT_CODE;
         cnt      <= '0;
         tries_q  <= '0;
         tick_cnt <= '0;
      end else begin
         key_q    <= key_onehot;
         key_prev <= key_q;
         state    <= state_n;
         disp     <= disp_n;
         code     <= code_n;
         cnt      <= cnt_n;
         tries_q  <= tries_n;
         tick_cnt <= tick_n;
      end
   end

   always_comb begin
      state_n    = state;
      disp_n     = disp;
      code_n     = code;
      cnt_n      = cnt;
      tries_n    = tries_q;
      tick_n     = tick_cnt;
      tone_start = 1'b0;
      tone_sel   = TONE_KEY;

      case (state)
         ST_ENTRY: begin
            if (press) begin
               if (is_digit) begin
                  if (!full) begin
                     disp_n     = shifted;
                     cnt_n      = cnt + 4'd1;
                     tone_start = 1'b1;
                  end
               end else if (key_idx == K_CLR_ENTRY || key_idx == K_CLR_ALL) begin
                  disp_n     = ALL_BLANK;
                  cnt_n      = '0;
                  tone_start = 1'b1;
                  if (key_idx == K_CLR_ALL) tries_n = '0;
               end else if (key_idx == K_ENTER && full) begin
                  cnt_n      = '0;
                  tone_start = 1'b1;
                  if (disp == code) begin
                     state_n  = ST_OPEN;
                     disp_n   = ALL_OPEN;
                     tries_n  = '0;
                     tone_sel = TONE_OK;
                  end else begin
                     disp_n   = ALL_BLANK;
                     tone_sel = TONE_FAIL;
                     if (tries_q + 4'd1 == TRY_LIMIT) begin
                        state_n = ST_LOCKOUT;
                        tries_n = '0;
                        disp_n  = W'(LOCK_BCD);
                        tick_n  = '0;
                     end else begin
                        tries_n = tries_q + 4'd1;
                     end
                  end
               end
            end
         end

         ST_OPEN: begin
            if (press) begin
               if (key_idx == K_ENTER || key_idx == K_CLR_ALL) begin
                  state_n    = ST_ENTRY;
                  disp_n     = ALL_BLANK;
                  cnt_n      = '0;
                  tone_start = 1'b1;
               end else if (key_idx == K_SET) begin
                  state_n    = ST_SET;
                  disp_n     = ALL_DASH;
                  cnt_n      = '0;
                  tone_start = 1'b1;
               end
            end
         end

         ST_SET: begin
            if (press) begin
               if (is_digit) begin
                  if (!full) begin
                     disp_n     = shifted;
                     cnt_n      = cnt + 4'd1;
                     tone_start = 1'b1;
                  end
               end else if (key_idx == K_CLR_ENTRY) begin
                  // Restart the new code, keeping the dash field visible
                  disp_n     = ALL_DASH;
                  cnt_n      = '0;
                  tone_start = 1'b1;
               end else if (key_idx == K_ENTER && full) begin
                  code_n     = disp;
                  state_n    = ST_ENTRY;
                  disp_n     = ALL_BLANK;
                  cnt_n      = '0;
                  tone_start = 1'b1;
                  tone_sel   = TONE_OK;
               end else if (key_idx == K_CLR_ALL) begin
                  state_n    = ST_OPEN;
                  disp_n     = ALL_OPEN;
                  cnt_n      = '0;
                  tone_start = 1'b1;
               end
            end
         end

         ST_LOCKOUT: begin
            // Keys are ignored; only the seconds countdown runs
            if (tick_cnt == TICK_LAST) begin
               tick_n = '0;
               if (disp[7:0] == 8'h01) begin
                  state_n = ST_ENTRY;
                  disp_n  = ALL_BLANK;
                  cnt_n   = '0;
               end else begin
                  disp_n = W'(bcd_dec2(disp[7:0]));
               end
            end else begin
               tick_n = tick_cnt + 32'd1;
            end
         end

         default: state_n = ST_ENTRY;
      endcase
   end

   buzz_gen #(.CLK_HZ(CLK_HZ)) u_buzz (
      .clk    (clk),
      .RSTn   (RSTn),
      .start  (tone_start),
      .tone   (tone_sel),
      .buzzer (buzzer)
   );

   assign disp_bcd  = disp;
   assign digit_cnt = cnt;
   assign tries     = tries_q;
   assign locked    = !(state == ST_OPEN || state == ST_SET);
   assign lockout   = (state == ST_LOCKOUT);
   assign state_dbg = state;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb_keypad_lock_ctrl
//   Bench for keypad_lock_ctrl with DIGITS=3, CLK_HZ=1000, MAX_TRIES=3,
//   LOCK_SECS=5, code 246. A reference model keeps the entered digits as
//   a list, the code as an array, and derives lockout countdown and
//   buzzer level from elapsed cycle counts.
module tb_keypad_lock_ctrl;

  localparam int CLK_HZ = 1000;
  localparam int LOCK_SECS = 5;
  localparam int M_ENTRY = 0, M_OPEN = 1, M_SET = 2, M_LOCK = 3;
  localparam int T_KEY = 0, T_OK = 1, T_FAIL = 2;
  localparam int B_ENTER = 0, B_SET = 4, B_CLR_ALL = 8, B_CLR_ENTRY = 12;

  logic        clk = 1'b0;
  logic        RSTn = 1'b1;
  logic [15:0] key_onehot = 16'd0;
  logic [11:0] disp_bcd;
  logic [3:0]  digit_cnt;
  logic [3:0]  tries;
  logic        locked, lockout, buzzer;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int dig_bit[10] = '{3, 7, 6, 5, 11, 10, 9, 15, 14, 13};

  // Reference model state
  int m_mode;
  int m_dig[$];
  int m_code[3];
  int m_tries;
  int lock_start;
  int tone_start;
  int tone_kind;

  keypad_lock_ctrl #(
    .DIGITS(3), .MAX_TRIES(3), .LOCK_SECS(LOCK_SECS), .CLK_HZ(CLK_HZ),
    .DEFAULT_CODE(12'h246)
  ) dut (
    .clk(clk), .RSTn(RSTn), .key_onehot(key_onehot), .disp_bcd(disp_bcd),
    .digit_cnt(digit_cnt), .tries(tries), .locked(locked), .lockout(lockout),
    .buzzer(buzzer), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic model_reset();
    m_mode = M_ENTRY;
    m_dig.delete();
    m_code = '{2, 4, 6};
    m_tries = 0;
    lock_start = 0;
    tone_start = -1;
    tone_kind = T_KEY;
  endtask

  // ---------------- reference model ----------------
  task automatic settle(input int c);
    if (m_mode == M_LOCK && (c - lock_start) >= LOCK_SECS * CLK_HZ) begin
      m_mode = M_ENTRY;
      m_dig.delete();
    end
  endtask

  task automatic beep(input int kind);
    tone_start = cyc;
    tone_kind = kind;
  endtask

  task automatic model_press(input int idx);
    int d;
    bit match;
    d = -1;
    for (int i = 0; i < 10; i++) if (dig_bit[i] == idx) d = i;
    case (m_mode)
      M_ENTRY, M_SET: begin
        if (d >= 0) begin
          if (m_dig.size() < 3) begin m_dig.push_back(d); beep(T_KEY); end
        end else if (idx == B_CLR_ENTRY) begin
          m_dig.delete(); beep(T_KEY);
        end else if (idx == B_CLR_ALL) begin
          m_dig.delete(); beep(T_KEY);
          if (m_mode == M_ENTRY) m_tries = 0; else m_mode = M_OPEN;
        end else if (idx == B_ENTER && m_dig.size() == 3) begin
          if (m_mode == M_SET) begin
            for (int i = 0; i < 3; i++) m_code[i] = m_dig[i];
            m_mode = M_ENTRY; beep(T_OK);
          end else begin
            match = 1;
            for (int i = 0; i < 3; i++) if (m_dig[i] != m_code[i]) match = 0;
            if (match) begin
              m_mode = M_OPEN; m_tries = 0; beep(T_OK);
            end else begin
              beep(T_FAIL);
              if (m_tries + 1 == 3) begin
                m_mode = M_LOCK; m_tries = 0; lock_start = cyc;
              end else m_tries++;
            end
          end
          m_dig.delete();
        end
      end
      M_OPEN: begin
        if (idx == B_ENTER || idx == B_CLR_ALL) begin m_mode = M_ENTRY; beep(T_KEY); end
        else if (idx == B_SET) begin m_mode = M_SET; beep(T_KEY); end
      end
      default: ;
    endcase
  endtask

  function automatic logic [11:0] exp_disp(input int c);
    logic [11:0] d;
    int s;
    case (m_mode)
      M_OPEN: d = 12'hBBB;
      M_LOCK: begin
        s = LOCK_SECS - (c - lock_start) / CLK_HZ;
        d = 12'(((s / 10) * 16) + (s % 10));
      end
      default: begin
        d = (m_mode == M_SET) ? 12'hDDD : 12'hFFF;
        for (int i = 0; i < m_dig.size(); i++) d[4*i +: 4] = 4'(m_dig[m_dig.size() - 1 - i]);
      end
    endcase
    return d;
  endfunction

  function automatic logic exp_buzz(input int c);
    int k, half, len;
    if (tone_start < 0) return 1'b0;
    k = c - tone_start;
    case (tone_kind)
      T_OK:    begin half = 1; len = 600; end
      T_FAIL:  begin half = 2; len = 300; end
      default: begin half = 1; len = 200; end
    endcase
    if (k >= len) return 1'b0;
    if (tone_kind == T_FAIL && k > len / 3 && k < (2 * len) / 3) return 1'b0;
    return ((k / half) % 2) == 0;
  endfunction

  // ---------------- driver ----------------
  // Drive mask, hold it for 'hold' cycles after it takes effect, release.
  task automatic press_mask(input logic [15:0] mask, input int hold);
    int idx;
    @(negedge clk) key_onehot = mask;
    @(negedge clk);
    @(negedge clk);
    if ($countones(mask) == 1) begin
      idx = 0;
      for (int i = 0; i < 16; i++) if (mask[i]) idx = i;
      settle(cyc - 1);
      model_press(idx);
    end
    repeat (hold - 1) @(negedge clk);
    key_onehot = 16'd0;
    @(negedge clk);
  endtask

  task automatic press(input int idx);
    press_mask(16'(1) << idx, 1);
  endtask

  task automatic press_digits(input int a, input int b, input int c);
    press(dig_bit[a]); press(dig_bit[b]); press(dig_bit[c]);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_all(input string name);
    logic [11:0] ed;
    settle(cyc);
    ed = exp_disp(cyc);
    checks++;
    if (disp_bcd !== ed) begin errors++;
      $display("FAIL %s disp: got %h want %h (cyc %0d)", name, disp_bcd, ed, cyc); end
    checks++;
    if (digit_cnt !== 4'((m_mode == M_ENTRY || m_mode == M_SET) ? m_dig.size() : 0)) begin errors++;
      $display("FAIL %s digit_cnt: got %0d want %0d", name, digit_cnt,
               (m_mode == M_ENTRY || m_mode == M_SET) ? m_dig.size() : 0); end
    checks++;
    if (tries !== 4'(m_tries)) begin errors++;
      $display("FAIL %s tries: got %0d want %0d", name, tries, m_tries); end
    checks++;
    if (locked !== (m_mode != M_OPEN && m_mode != M_SET)) begin errors++;
      $display("FAIL %s locked: got %b want %b", name, locked, (m_mode != M_OPEN && m_mode != M_SET)); end
    checks++;
    if (lockout !== (m_mode == M_LOCK)) begin errors++;
      $display("FAIL %s lockout: got %b want %b", name, lockout, (m_mode == M_LOCK)); end
    checks++;
    if (buzzer !== exp_buzz(cyc)) begin errors++;
      $display("FAIL %s buzzer: got %b want %b (cyc %0d)", name, buzzer, exp_buzz(cyc), cyc); end
  endtask

  task automatic check_buzz_window(input int n, input string name);
    int bad, first_bad;
    logic first_got;
    bad = 0; first_bad = -1; first_got = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (buzzer !== exp_buzz(cyc)) begin
        if (bad == 0) begin first_bad = cyc - tone_start; first_got = buzzer; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin errors++;
      $display("FAIL %s buzzer pattern: %0d bad cycles, first at offset %0d got %b want %b",
               name, bad, first_bad, first_got, ~first_got); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    RSTn = 1'b1;
    repeat (3) @(negedge clk);
    RSTn = 1'b0;
    @(negedge clk);
    check_all("reset");
  endtask

  task automatic test_open();
    press(dig_bit[2]); check_all("open_k2");
    press(dig_bit[4]); check_all("open_k4");
    press(dig_bit[6]); check_all("open_k6");
    press(B_ENTER);    check_all("open_enter");
    check_buzz_window(650, "open_ok_tone");
    check_all("open_after_tone");
    press(B_ENTER);    check_all("open_relock");
  endtask

  task automatic test_overflow();
    press_digits(1, 2, 3); check_all("ovf_123");
    press(dig_bit[4]);     check_all("ovf_4th_ignored");
    press(B_ENTER);        check_all("ovf_enter_fail");
    check_buzz_window(320, "ovf_fail_tone");
  endtask

  task automatic test_lockout();
    int ls;
    press(B_ENTER); check_all("lock_short_enter");
    press_digits(7, 7, 7); press(B_ENTER); check_all("lock_try2");
    press_digits(8, 8, 8); press(B_ENTER); check_all("lock_enter");
    ls = lock_start;
    wait_until(ls + 999);  check_all("lock_999");
    wait_until(ls + 1000); check_all("lock_1000");
    press(dig_bit[2]); press(B_CLR_ALL); press(B_ENTER); check_all("lock_keys_ignored");
    wait_until(ls + 4999); check_all("lock_4999");
    wait_until(ls + 5000); check_all("lock_5000_expired");
  endtask

  task automatic test_set();
    press_digits(2, 4, 6); press(B_ENTER); check_all("set_open");
    press(dig_bit[3]);     check_all("set_open_digit_ignored");
    press(B_SET);          check_all("set_enter_set");
    press(dig_bit[9]);     check_all("set_k9");
    press(dig_bit[0]);     check_all("set_k0");
    press(dig_bit[1]);     check_all("set_k1");
    press(B_ENTER);        check_all("set_store");
    press_digits(2, 4, 6); press(B_ENTER); check_all("set_old_code_fails");
    press_digits(9, 0, 1); press(B_ENTER); check_all("set_new_code_opens");
    press(B_SET); press(dig_bit[5]); press(B_CLR_ALL); check_all("set_abort");
    press(B_CLR_ALL);      check_all("set_relock");
  endtask

  task automatic test_hold_multihot_reset();
    press_mask(16'(1) << dig_bit[1], 50); check_all("hold_one_digit");
    press_mask(16'h0088, 3);               check_all("multihot_ignored");
    press(dig_bit[5]);                     check_all("before_reset");
    @(negedge clk);
    #2 RSTn = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk) RSTn = 1'b0;
    @(negedge clk);
    press_digits(2, 4, 6); press(B_ENTER); check_all("reset_code_restored");
    press(B_ENTER); check_all("reset_relock");
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 70; n++) begin
      if (m_mode == M_LOCK) begin
        wait_until(lock_start + LOCK_SECS * CLK_HZ + 1);
        check_all("rand_lock_end");
      end
      r = $urandom_range(0, 99);
      if (r < 50)      press(dig_bit[$urandom_range(0, 9)]);
      else if (r < 62) press(B_ENTER);
      else if (r < 70) press(B_CLR_ENTRY);
      else if (r < 75) press(B_CLR_ALL);
      else if (r < 85) press(B_SET);
      else if (r < 90) press($urandom_range(1, 2));
      else begin
        press_digits(m_code[0], m_code[1], m_code[2]);
        press(B_ENTER);
      end
      repeat ($urandom_range(0, 40)) @(negedge clk);
      check_all("rand");
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_overflow();
    test_lockout();
    test_set();
    test_hold_multihot_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
